// File: rtl/fp_multiplier_pipe.sv
// Pipelined floating-point multiplier: operand capture, classify, multiply, normalise/round/pack.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated toward zero.
module fp_multiplier_pipe #(
    parameter  int EXP_W      = 5,
    parameter  int MAN_W      = 10,
    localparam int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic [2:0]            flags
);
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
`ifdef FPMUL_RNE_EN
    localparam int LSB = 0;
`else
    localparam int LSB = MAN_W;
`endif
    localparam int KW = PW - LSB;
    localparam logic signed [EW-1:0] BIAS_S  = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S  = EW'(0);

    typedef enum logic [1:0] {SPC_NORM, SPC_ZERO, SPC_INF, SPC_NAN} spc_e;

    function automatic spc_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return SPC_ZERO;
        else if (e == '1)
            return (f == '0) ? SPC_INF : SPC_NAN;
        else
            return SPC_NORM;
    endfunction

    function automatic spc_e combine(input spc_e x, input spc_e y);
        if (x == SPC_NAN || y == SPC_NAN)
            return SPC_NAN;
        if ((x == SPC_INF && y == SPC_ZERO) || (x == SPC_ZERO && y == SPC_INF))
            return SPC_NAN;
        if (x == SPC_INF || y == SPC_INF)
            return SPC_INF;
        if (x == SPC_ZERO || y == SPC_ZERO)
            return SPC_ZERO;
        return SPC_NORM;
    endfunction

    // Saturating pack of a normal result: {result, invalid, overflow, underflow}
    function automatic logic [DATA_WIDTH+2:0] pack_normal(input logic s,
                                                          input logic signed [EW-1:0] e,
                                                          input logic [MAN_W-1:0] f);
        if (e >= EXP_MAX)
            return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 3'b010};
        else if (e <= ZERO_S)
            return {s, {(EXP_W + MAN_W){1'b0}}, 3'b001};
        else
            return {s, e[EXP_W-1:0], f, 3'b000};
    endfunction

`ifdef FPMUL_RNE_EN
    function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] f,
                                                 input logic g, input logic st);
        return {1'b0, f} + {{MAN_W{1'b0}}, g & (st | f[0])};
    endfunction
`endif

    // Stage p0: operand capture
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] a_p0, b_p0;
    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;

    assign {sa, ea, fa} = a_p0;
    assign {sb, eb, fb} = b_p0;

    // Stage p1: sign, biased exponent sum, special-case code
    logic                 vld_p1, sign_p1;
    logic signed [EW-1:0] exp_p1;
    logic [MAN_W:0]       man_a_p1, man_b_p1;
    spc_e                 spc_p1;

    // Stage p2: significand product (low bits dropped when truncating)
    logic                 vld_p2, sign_p2;
    logic signed [EW-1:0] exp_p2;
    logic [KW-1:0]        prod_p2;
    spc_e                 spc_p2;

    always_ff @(posedge clk) begin
        if (en) begin
            a_p0     <= a;
            b_p0     <= b;
            sign_p1  <= sa ^ sb;
            exp_p1   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
            man_a_p1 <= {1'b1, fa};
            man_b_p1 <= {1'b1, fb};
            spc_p1   <= combine(classify(ea, fa), classify(eb, fb));
            sign_p2  <= sign_p1;
            exp_p2   <= exp_p1;
            spc_p2   <= spc_p1;
            prod_p2  <= KW'((PW'(man_a_p1) * PW'(man_b_p1)) >> LSB);
        end
    end

    // Stage p3: normalise, round, pack, flag
    logic [MAN_W-1:0]      frac_n;
    logic signed [EW-1:0]  exp_n;
    logic [DATA_WIDTH-1:0] res_n;
    logic [2:0]            flg_n;
`ifdef FPMUL_RNE_EN
    logic                  guard_n, sticky_n;
    logic [MAN_W:0]        frac_r;
`endif

    always_comb begin
        exp_n  = exp_p2;
        frac_n = prod_p2[KW-3 -: MAN_W];
`ifdef FPMUL_RNE_EN
        guard_n  = prod_p2[MAN_W-1];
        sticky_n = |prod_p2[MAN_W-2:0];
`endif
        if (prod_p2[KW-1]) begin
            exp_n  = exp_p2 + ONE_S;
            frac_n = prod_p2[KW-2 -: MAN_W];
`ifdef FPMUL_RNE_EN
            guard_n  = prod_p2[MAN_W];
            sticky_n = |prod_p2[MAN_W-1:0];
`endif
        end
`ifdef FPMUL_RNE_EN
        frac_r = round_rne(frac_n, guard_n, sticky_n);
        if (frac_r[MAN_W])
            exp_n = exp_n + ONE_S;
        frac_n = frac_r[MAN_W-1:0];
`endif
        res_n = '0;
        flg_n = '0;
        case (spc_p2)
            SPC_NAN:  begin
                res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
                flg_n = 3'b100;
            end
            SPC_INF:  res_n = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SPC_ZERO: res_n = {sign_p2, {(EXP_W + MAN_W){1'b0}}};
            default:  {res_n, flg_n} = pack_normal(sign_p2, exp_n, frac_n);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            if (vld_p2) begin
                result <= res_n;
                flags  <= flg_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Scoreboard bench for fp_multiplier_pipe (FP16 defaults): directed spec vectors plus randomized
// traffic with stalls, bubbles and a mid-stream reset, checked against a value-level reference model.
module tb_fp_multiplier_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [15:0] a, b;
    logic        out_valid;
    logic [15:0] result;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    fp_multiplier_pipe dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .a(a), .b(b), .out_valid(out_valid), .result(result), .flags(flags)
    );

    typedef struct packed {
        logic        vld;
        logic        chk;
        logic [15:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: exact integer product of significands, then round/saturate by value.
    function automatic logic [18:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int   ex, ey, be, n, sh;
        longint fx, fy, p, q, rem, half;
        logic nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        fx = longint'(x[9:0]);
        fy = longint'(y[9:0]);
        nan_x = (ex == 31) && (fx != 0);
        nan_y = (ey == 31) && (fy != 0);
        inf_x = (ex == 31) && (fx == 0);
        inf_y = (ey == 31) && (fy == 0);
        zero_x = (ex == 0);
        zero_y = (ey == 0);
        if (nan_x || nan_y) return {16'h7E00, 3'b100};
        if ((inf_x && zero_y) || (inf_y && zero_x)) return {16'h7E00, 3'b100};
        if (inf_x || inf_y) return {s, 15'h7C00, 3'b000};
        if (zero_x || zero_y) return {s, 15'h0000, 3'b000};
        p = (1024 + fx) * (1024 + fy);
        n = 0;
        for (int i = 0; i < 64; i++)
            if (p[i]) n = i;
        sh   = n - 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        be   = ex + ey - 15 + (n - 20);
`ifdef FPMUL_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == 2048) begin
            q  = 1024;
            be = be + 1;
        end
`else
        if (rem > half) q = q;
`endif
        if (be >= 31) return {s, 15'h7C00, 3'b010};
        if (be <= 0)  return {s, 15'h0000, 3'b001};
        return {s, be[4:0], q[9:0], 3'b000};
    endfunction

    function automatic logic [15:0] rand_op();
        logic       s;
        logic [4:0] e;
        logic [9:0] f;
        s = 1'($urandom);
        f = 10'($urandom);
        case ($urandom % 8)
            0:       e = 5'd0;
            1:       e = 5'd31;
            2:       e = 5'(24 + $urandom % 7);
            3:       e = 5'(1 + $urandom % 8);
            default: e = 5'(1 + $urandom % 30);
        endcase
        return {s, e, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Issue one cycle of stimulus; an enabled cycle's expected output is queued.
    task automatic drive(input logic e, input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic has_exp, input logic [18:0] ex);
        exp_t t;
        @(negedge clk);
        en       = e;
        in_valid = v;
        a        = x;
        b        = y;
        if (e) begin
            t.vld = v;
            t.chk = v;
            {t.res, t.flg} = has_exp ? ex : ref_mul(x, y);
            sb_q.push_back(t);
        end
    endtask

    task automatic preload();
        exp_t t;
        t = '0;
        sb_q.delete();
        repeat (3) sb_q.push_back(t);
    endtask

    // Monitor: every enabled edge retires one scoreboard entry; stalled edges must hold.
    initial begin
        exp_t last, cur;
        logic en_s, rst_s;
        last = '0;
        last.chk = 1'b1;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = reset;
            #1;
            if (rst_s || reset) begin
                last = '0;
                last.chk = 1'b1;
            end else if (en_s) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got out_valid=%b, expected a queued entry", out_valid);
                end else begin
                    cur = sb_q.pop_front();
                    check("out_valid", 32'(out_valid), 32'(cur.vld));
                    if (cur.chk) begin
                        check("result", 32'(result), 32'(cur.res));
                        check("flags", 32'(flags), 32'(cur.flg));
                    end
                    last = cur;
                end
            end else begin
                check("hold_out_valid", 32'(out_valid), 32'(last.vld));
                if (last.chk) begin
                    check("hold_result", 32'(result), 32'(last.res));
                    check("hold_flags", 32'(flags), 32'(last.flg));
                end
            end
        end
    end

    logic [15:0] dir_a   [14] = '{16'h3E00, 16'hC000, 16'h3C01, 16'h7C00, 16'h7E01, 16'hFC00, 16'h7BFF,
                                  16'h0400, 16'h8400, 16'h3C00, 16'h0000, 16'hFC00, 16'h7C00, 16'h3800};
    logic [15:0] dir_b   [14] = '{16'h4000, 16'h3800, 16'h3E00, 16'h0000, 16'h3C00, 16'h4000, 16'h7BFF,
                                  16'h0400, 16'h0400, 16'h3C00, 16'h8000, 16'hFC00, 16'h7E00, 16'h8000};
    logic [15:0] dir_res [14] = '{16'h4200, 16'hBC00, 16'h3E01, 16'h7E00, 16'h7E00, 16'hFC00, 16'h7C00,
                                  16'h0000, 16'h8000, 16'h3C00, 16'h8000, 16'h7C00, 16'h7E00, 16'h8000};
    logic [2:0]  dir_flg [14] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b010,
                                  3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
`ifdef FPMUL_RNE_EN
        dir_res[2] = 16'h3E02;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        preload();
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            drive(1'b1, 1'b1, dir_a[i], dir_b[i], 1'b1, {dir_res[i], dir_flg[i]});
        repeat (3) drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 19'h0);

        for (int i = 0; i < 8; i++) begin
            if (i == 4)
                repeat (2) drive(1'b0, 1'b1, rand_op(), rand_op(), 1'b0, 19'h0);
            drive(1'b1, 1'b1, rand_op(), rand_op(), 1'b0, 19'h0);
        end

        for (int i = 0; i < 24; i++)
            drive(1'b1, 1'($urandom), rand_op(), rand_op(), 1'b0, 19'h0);

        for (int i = 0; i < 400; i++)
            drive(($urandom % 5) != 0, ($urandom % 4) != 0, rand_op(), rand_op(), 1'b0, 19'h0);

        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b1, 16'h3C00 + 16'(i), 16'h4000, 1'b0, 19'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_flags", 32'(flags), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload();
        en       = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (6) drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 19'h0);

        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, rand_op(), rand_op(), 1'b0, 19'h0);
        repeat (5) drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 19'h0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
